// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tribus_rx.sv
// Receive-side direction controller and FWFT capture FIFO for a half-duplex bufz bus.
// Optional parity check: define GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN to add bus_p/perr.
module gf180mcu_fd_sc_mcu7t5v0__tribus_rx #(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int TA_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rn,
  input  logic                       dir_req,
  input  logic [W-1:0]               bus_i,
  input  logic                       bus_vld,
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
  input  logic                       bus_p,
  output logic                       perr,
`endif
  output logic                       local_en,
  output logic                       rx_act,
  input  logic                       rd,
  output logic [W-1:0]               data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TA_CYC) + 1;
  localparam logic [TW-1:0] TA_LOAD = TW'(TA_CYC - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_TA, ST_RX, ST_TX} state_t;

  state_t          state_r, state_s;
  logic            target_tx_r, target_tx_s;
  logic [TW-1:0]   ta_cnt_r, ta_cnt_s;
  logic            local_en_r;

  logic [W-1:0]    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, head_idx_s;
  logic [CW-1:0]   count_r, count_s;
  logic            empty_r, full_r, ovf_r;
  logic [W-1:0]    data_r, head_val_s;
  logic            capture_s, par_ok_s, push_s, pop_s, drop_s;

`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
  logic            perr_r;

  function automatic logic even_parity_ok(input logic [W-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  // Direction FSM: every direction change passes through a full turnaround gap.
  always_comb begin
    state_s     = state_r;
    target_tx_s = target_tx_r;
    ta_cnt_s    = ta_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (dir_req) begin
          state_s = ST_RX;
        end else begin
          state_s     = ST_TA;
          target_tx_s = 1'b1;
          ta_cnt_s    = TA_LOAD;
        end
      end
      ST_RX: begin
        if (!dir_req) begin
          state_s     = ST_TA;
          target_tx_s = 1'b1;
          ta_cnt_s    = TA_LOAD;
        end else begin
          state_s = ST_RX;
        end
      end
      ST_TX: begin
        if (dir_req) begin
          state_s     = ST_TA;
          target_tx_s = 1'b0;
          ta_cnt_s    = TA_LOAD;
        end else begin
          state_s = ST_TX;
        end
      end
      ST_TA: begin
        if (ta_cnt_r == {TW{1'b0}}) begin
          state_s = target_tx_r ? ST_TX : ST_RX;
        end else begin
          ta_cnt_s = ta_cnt_r - TW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, turnaround counter and the registered bus drive enable.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_r     <= ST_IDLE;
      target_tx_r <= 1'b0;
      ta_cnt_r    <= {TW{1'b0}};
      local_en_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      target_tx_r <= target_tx_s;
      ta_cnt_r    <= ta_cnt_s;
      local_en_r  <= (state_s == ST_TX);
    end
  end

  // Capture qualification, push/pop arbitration and the next FWFT head value.
  always_comb begin
    capture_s = (state_r == ST_RX) && bus_vld;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
    par_ok_s  = even_parity_ok(bus_i, bus_p);
`else
    par_ok_s  = 1'b1;
`endif
    pop_s     = rd && !empty_r;
    push_s    = capture_s && par_ok_s && (!full_r || rd);
    drop_s    = capture_s && par_ok_s && full_r && !rd;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
    if (pop_s) begin
      head_idx_s = rd_ptr_r + AW'(1);
    end else begin
      head_idx_s = rd_ptr_r;
    end
    // The word written this edge becomes head when it lands where the head will point.
    if (push_s && (wr_ptr_r == head_idx_s)) begin
      head_val_s = bus_i;
    end else begin
      head_val_s = mem_r[head_idx_s];
    end
  end

  // FIFO storage, pointers, flags and sticky error bits.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      mem_r    <= '{default: {W{1'b0}}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      data_r   <= {W{1'b0}};
      ovf_r    <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
      perr_r   <= 1'b0;
`endif
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus_i;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
      empty_r <= (count_s == {CW{1'b0}});
      full_r  <= (count_s == DEPTH_C);
      if (count_s != {CW{1'b0}}) begin
        data_r <= head_val_s;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
      if (capture_s && !par_ok_s) begin
        perr_r <= 1'b1;
      end else if (ovf_clr) begin
        perr_r <= 1'b0;
      end
`endif
    end
  end

  assign local_en = local_en_r;
  assign rx_act   = (state_r == ST_RX);
  assign data     = data_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;
  assign ovf      = ovf_r;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
  assign perr     = perr_r;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__tribus_rx.sv
// Directed plus randomized bench for the tristate-bus receive controller,
// checked against a queue-based behavioural model of direction and FIFO rules.
module tb_gf180mcu_fd_sc_mcu7t5v0__tribus_rx;

  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int TA_CYC = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int M_IDLE = 0, M_TA = 1, M_RX = 2, M_TX = 3;

  logic          clk = 1'b0;
  logic          rn = 1'b0;
  logic          dir_req = 1'b1;
  logic [W-1:0]  bus_i = '0;
  logic          bus_vld = 1'b0;
  logic          rd = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          local_en, rx_act, empty, full, ovf;
  logic [W-1:0]  data;
  logic [CW-1:0] count;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
  logic          bus_p = 1'b0;
  logic          perr;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  int           m_state, m_ta_left;
  bit           m_target_tx, m_ovf, m_perr;
  logic [W-1:0] m_data;

  gf180mcu_fd_sc_mcu7t5v0__tribus_rx #(.W(W), .DEPTH(DEPTH), .TA_CYC(TA_CYC)) dut (
    .clk(clk), .rn(rn), .dir_req(dir_req), .bus_i(bus_i), .bus_vld(bus_vld),
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
    .bus_p(bus_p), .perr(perr),
`endif
    .local_en(local_en), .rx_act(rx_act), .rd(rd), .data(data), .empty(empty),
    .full(full), .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = M_IDLE; m_ta_left = 0; m_target_tx = 1'b0;
    m_data = '0; m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  task automatic enter_ta(input bit to_tx);
    m_state = M_TA; m_ta_left = TA_CYC; m_target_tx = to_tx;
  endtask

  // Applies one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    bit cap, ok, room;
    cap  = (m_state == M_RX) && bus_vld;
    ok   = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
    ok   = (($countones(bus_i) + int'(bus_p)) % 2) == 0;
`endif
    room = (q.size() < DEPTH) || rd;
    if (cap && !ok) m_perr = 1'b1; else if (ovf_clr) m_perr = 1'b0;
    if (cap && ok && !room) m_ovf = 1'b1; else if (ovf_clr) m_ovf = 1'b0;
    if (rd && q.size() > 0) void'(q.pop_front());
    if (cap && ok && room) q.push_back(bus_i);
    if (q.size() > 0) m_data = q[0];
    case (m_state)
      M_IDLE: if (dir_req) m_state = M_RX; else enter_ta(1'b1);
      M_RX:   if (!dir_req) enter_ta(1'b1);
      M_TX:   if (dir_req) enter_ta(1'b0);
      default: begin
        m_ta_left--;
        if (m_ta_left == 0) m_state = m_target_tx ? M_TX : M_RX;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".local_en"}, local_en, m_state == M_TX);
    chk({tag, ".rx_act"},   rx_act,   m_state == M_RX);
    chk({tag, ".data"},     data,     m_data);
    chk({tag, ".empty"},    empty,    q.size() == 0);
    chk({tag, ".full"},     full,     q.size() == DEPTH);
    chk({tag, ".count"},    count,    q.size());
    chk({tag, ".ovf"},      ovf,      m_ovf);
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
    chk({tag, ".perr"},     perr,     m_perr);
`endif
  endtask

  task automatic drive(input logic d, input logic v, input logic [W-1:0] b,
                       input logic r, input logic c);
    dir_req = d; bus_vld = v; bus_i = b; rd = r; ovf_clr = c;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
    bus_p = ^b;
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] v;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rn = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick("to_rx");

    // Fill and overflow
    for (int i = 0; i < 5; i++) begin
      v = 8'h11 * (i + 1);
      drive(1'b1, 1'b1, v, 1'b0, 1'b0);
      tick("fill");
    end
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 3'd4);
    chk("fill_ovf", ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      v = 8'h11 * (i + 1);
      chk("fill_pop_data", data, v);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      tick("fill_pop");
    end
    chk("fill_drained", empty, 1'b1);

    // Push while full with simultaneous pop
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick("ovf_clr");
    chk("ovf_cleared", ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = 8'hA0 + 8'(i);
      drive(1'b1, 1'b1, v, 1'b0, 1'b0);
      tick("fullrd_fill");
    end
    drive(1'b1, 1'b1, 8'hB0, 1'b1, 1'b0);
    tick("fullrd_push");
    chk("fullrd_data", data, 8'hA1);
    chk("fullrd_count", count, 3'd4);
    chk("fullrd_ovf", ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = (i == 3) ? 8'hB0 : 8'hA1 + 8'(i);
      chk("fullrd_pop_data", data, v);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      tick("fullrd_pop");
    end

    // Pointer wrap with interleaved push/pop
    for (int i = 0; i < 10; i++) begin
      v = 8'(i);
      drive(1'b1, 1'b1, v, 1'b0, 1'b0);
      tick("wrap_push");
      chk("wrap_data", data, v);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
      tick("wrap_pop");
    end
    chk("wrap_empty", empty, 1'b1);

    // Turnaround RX -> TX -> RX
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < TA_CYC + 1; i++) tick("to_tx");
    chk("tx_local_en", local_en, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick("ta_enter");
    chk("ta_local_en_drop", local_en, 1'b0);
    drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    tick("ta_mid");
    chk("ta_rx_act_early", rx_act, 1'b0);
    tick("ta_end");
    chk("ta_rx_act", rx_act, 1'b1);
    chk("ta_no_capture", count, 3'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
    drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    bus_p = 1'b1;
    tick("par_bad");
    chk("par_perr", perr, 1'b1);
    chk("par_not_stored", count, 3'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick("par_clr");
    chk("par_perr_clr", perr, 1'b0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(15) == 0) ? ~dir_req : dir_req, 1'($urandom_range(1)),
            W'($urandom), ($urandom_range(9) < 4), ($urandom_range(19) == 0));
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_RX_PARITY_EN
      if ($urandom_range(7) == 0) bus_p = ~bus_p;
`endif
      tick("rand");
    end

    // Asynchronous reset mid-RX with three words held
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick("drain");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      tick("pre_rst");
    end
    chk("pre_rst_count", count, 3'd3);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    #2 rn = 1'b0;
    #1;
    model_reset();
    chk("rst_local_en", local_en, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_data", data, 8'h00);
    @(negedge clk);
    rn = 1'b1;
    tick("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
